// File: rtl/alu_frame_responder.sv
// Framed echo/add/xor command responder between UART rx and tx streams.
// Optional 0xEE error reply: define ALU_FRAME_RESP_ERR_REPLY_EN.
module alu_frame_responder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam logic [2:0] S_OPCODE  = 3'd0;
    localparam logic [2:0] S_RSVD    = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_LEN_HI  = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_RESULT  = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
`ifdef ALU_FRAME_RESP_ERR_REPLY_EN
    localparam logic [2:0] S_ERR     = 3'd7;
`endif

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_XOR  = 8'hB0;

    logic [2:0]  state_q;
    logic [7:0]  op_q;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;
    logic [23:0] opnd_q;
    logic [31:0] acc_q;
    logic [1:0]  res_cnt_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        err_q;
    logic        rdy_en_q;

    logic        s_acc;
    logic        m_xfer;
    logic        rdy_lvl;
    logic        is_echo;
    logic        is_add;
    logic        is_alu;
    logic        frame_bad;
    logic [15:0] len_w;
    logic [31:0] opnd_w;
    logic [31:0] acc_w;

    assign is_echo = (op_q == OP_ECHO);
    assign is_add  = (op_q == OP_ADD);
    assign is_alu  = is_add || (op_q == OP_XOR);

    assign len_w  = {s_axis_tdata, len_lo_q};
    assign opnd_w = {s_axis_tdata, opnd_q};
    assign acc_w  = is_add ? (acc_q + opnd_w) : (acc_q ^ opnd_w);

    // (len - 4) is a nonzero multiple of 4 iff len is a multiple of 4 above 4
    assign frame_bad = (len_w < 16'd4)
                     || !(is_echo || is_alu)
                     || (is_alu && ((len_w[1:0] != 2'd0) || (len_w == 16'd4)));

    always_comb begin
        rdy_lvl = 1'b0;
        case (state_q)
            S_OPCODE, S_RSVD,
            S_LEN_LO, S_LEN_HI: rdy_lvl = 1'b1;
            S_PAYLOAD: rdy_lvl = is_echo ? (!m_valid_q || m_axis_tready) : 1'b1;
            S_DRAIN:   rdy_lvl = (rem_q != 16'd0);
            default:   rdy_lvl = 1'b0;
        endcase
    end

    assign s_axis_tready = rdy_en_q && rdy_lvl;
    assign s_acc         = s_axis_tvalid && s_axis_tready;
    assign m_xfer        = m_valid_q && m_axis_tready;

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign busy_o        = (state_q != S_OPCODE);
    assign err_o         = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OPCODE;
            op_q      <= 8'h00;
            len_lo_q  <= 8'h00;
            rem_q     <= 16'd0;
            opnd_q    <= 24'd0;
            acc_q     <= 32'd0;
            res_cnt_q <= 2'd0;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= 1'b0;
            if (m_xfer) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                S_OPCODE: begin
                    if (s_acc) begin
                        op_q    <= s_axis_tdata;
                        state_q <= S_RSVD;
                    end
                end
                S_RSVD: begin
                    if (s_acc) begin
                        state_q <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (s_acc) begin
                        len_lo_q <= s_axis_tdata;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (s_acc) begin
                        acc_q  <= 32'd0;
                        opnd_q <= 24'd0;
                        rem_q  <= (len_w < 16'd4) ? 16'd0 : (len_w - 16'd4);
                        if (frame_bad) begin
                            err_q   <= 1'b1;
                            state_q <= S_DRAIN;
                        end else if (is_echo && (len_w == 16'd4)) begin
                            state_q <= S_OPCODE;
                        end else begin
                            state_q <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (s_acc) begin
                        rem_q <= rem_q - 16'd1;
                        if (is_echo) begin
                            m_data_q  <= s_axis_tdata;
                            m_valid_q <= 1'b1;
                            if (rem_q == 16'd1) begin
                                res_cnt_q <= 2'd0;
                                state_q   <= S_RESULT;
                            end
                        end else begin
                            // rem counts down, so rem mod 4 gives the byte lane
                            case (rem_q[1:0])
                                2'd0:    opnd_q[7:0]   <= s_axis_tdata;
                                2'd3:    opnd_q[15:8]  <= s_axis_tdata;
                                2'd2:    opnd_q[23:16] <= s_axis_tdata;
                                default: acc_q         <= acc_w;
                            endcase
                            if (rem_q == 16'd1) begin
                                m_data_q  <= acc_w[7:0];
                                m_valid_q <= 1'b1;
                                acc_q     <= {8'h00, acc_w[31:8]};
                                res_cnt_q <= 2'd3;
                                state_q   <= S_RESULT;
                            end
                        end
                    end
                end
                S_RESULT: begin
                    if (m_xfer) begin
                        if (res_cnt_q != 2'd0) begin
                            m_data_q  <= acc_q[7:0];
                            m_valid_q <= 1'b1;
                            acc_q     <= {8'h00, acc_q[31:8]};
                            res_cnt_q <= res_cnt_q - 2'd1;
                        end else begin
                            state_q <= S_OPCODE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rem_q == 16'd0) begin
`ifdef ALU_FRAME_RESP_ERR_REPLY_EN
                        m_data_q  <= 8'hEE;
                        m_valid_q <= 1'b1;
                        state_q   <= S_ERR;
`else
                        state_q   <= S_OPCODE;
`endif
                    end else if (s_acc) begin
                        rem_q <= rem_q - 16'd1;
                    end
                end
`ifdef ALU_FRAME_RESP_ERR_REPLY_EN
                S_ERR: begin
                    if (m_xfer) begin
                        state_q <= S_OPCODE;
                    end
                end
`endif
                default: state_q <= S_OPCODE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_responder.sv
// Directed self-checking bench for alu_frame_responder.
// Honours ALU_FRAME_RESP_ERR_REPLY_EN for the error-reply expectation.
module tb_alu_frame_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       busy_o;
    logic       err_o;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int rx_mark = 0;
    int err_mark = 0;
    logic [7:0] rxq[$];
    logic [7:0] f[$];
    logic [7:0] e[$];

    alu_frame_responder #(.DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) rxq.push_back(m_axis_tdata);
        if (rst_n && err_o) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("send_ready", {31'd0, s_axis_tready}, 32'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic mark();
        rx_mark  = rxq.size();
        err_mark = err_pulses;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] q[$]);
        chk({tag, "_count"}, rxq.size() - rx_mark, q.size());
        foreach (q[i]) begin
            if (rx_mark + i < rxq.size())
                chk(tag, {24'd0, rxq[rx_mark + i]}, {24'd0, q[i]});
        end
    endtask

    initial begin
        // reset values
        #2;
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tready_pre", {31'd0, s_axis_tready}, 32'd0);
        @(posedge clk);
        #1;
        chk("tready_post", {31'd0, s_axis_tready}, 32'd1);

        // echo
        mark();
        f = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_frame(f);
        wait_idle("echo_idle");
        e = '{8'h41, 8'h42, 8'h43};
        expect_rx("echo", e);

        // echo with length 4: no response
        mark();
        f = '{8'hEC, 8'h00, 8'h04, 8'h00};
        send_frame(f);
        chk("echo4_busy", {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk);
        e = '{};
        expect_rx("echo4", e);

        // add with wrap
        mark();
        f = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(f);
        wait_idle("addw_idle");
        e = '{8'h00, 8'h00, 8'h00, 8'h00};
        expect_rx("add_wrap", e);

        // add with carries and first-byte latency
        mark();
        f = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'h11, 8'h11, 8'h11, 8'h11};
        send_frame(f);
        chk("add_lat_valid", {31'd0, m_axis_tvalid}, 32'd1);
        chk("add_lat_data", {24'd0, m_axis_tdata}, 32'h89);
        wait_idle("add_idle");
        e = '{8'h89, 8'h67, 8'h45, 8'h23};
        expect_rx("add", e);

        // xor of three operands
        mark();
        f = '{8'hB0, 8'h00, 8'h10, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00,
              8'hF0, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00};
        send_frame(f);
        wait_idle("xor_idle");
        e = '{8'h55, 8'h00, 8'h00, 8'h00};
        expect_rx("xor", e);

        // backpressure on echo
        mark();
        m_axis_tready = 1'b0;
        f = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11};
        send_frame(f);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) begin
                chk("bp_valid", {31'd0, m_axis_tvalid}, 32'd1);
                chk("bp_data", {24'd0, m_axis_tdata}, 32'h11);
            end
        end
        chk("bp_sready", {31'd0, s_axis_tready}, 32'd0);
        m_axis_tready = 1'b1;
        send_byte(8'h22);
        wait_idle("bp_idle");
        e = '{8'h11, 8'h22};
        expect_rx("bp", e);

        // malformed add frame
        mark();
        f = '{8'hA0, 8'h00, 8'h07, 8'h00};
        send_frame(f);
        chk("bad_err_pulse", {31'd0, err_o}, 32'd1);
        f = '{8'h01, 8'h02, 8'h03};
        send_frame(f);
        wait_idle("bad_idle");
        chk("bad_err_count", err_pulses - err_mark, 1);
`ifdef ALU_FRAME_RESP_ERR_REPLY_EN
        e = '{8'hEE};
`else
        e = '{};
`endif
        expect_rx("bad", e);

        mark();
        f = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        send_frame(f);
        wait_idle("post_bad_idle");
        e = '{8'h05, 8'h00, 8'h00, 8'h00};
        expect_rx("post_bad_add", e);

        // short length: immediate drain exit
        mark();
        f = '{8'hEC, 8'h00, 8'h02, 8'h00};
        send_frame(f);
        wait_idle("short_idle");
        chk("short_err_count", err_pulses - err_mark, 1);
`ifdef ALU_FRAME_RESP_ERR_REPLY_EN
        e = '{8'hEE};
`else
        e = '{};
`endif
        expect_rx("short", e);

        // unknown opcode
        mark();
        f = '{8'h55, 8'h00, 8'h05, 8'h00, 8'h99};
        send_frame(f);
        wait_idle("unk_idle");
        chk("unk_err_count", err_pulses - err_mark, 1);

        // mid-frame reset
        f = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
        send_frame(f);
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("mr_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("mr_tdata", {24'd0, m_axis_tdata}, 32'd0);
        chk("mr_busy", {31'd0, busy_o}, 32'd0);
        chk("mr_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mark();
        f = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_frame(f);
        wait_idle("mr_idle");
        e = '{8'h5A};
        expect_rx("mr_echo", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_frame_responder.md
# alu_frame_responder

Command-side endpoint of the UART ALU link. Consumes bytes from the UART receiver's AXI-stream output and parses framed commands (opcode, reserved, 16-bit length, payload). It executes echo, 32-bit add or 32-bit xor, and streams response bytes to the UART transmitter's AXI-stream input. It sits inside `top` between the `uart` receive and transmit channels, and answers the frames the bench's host-side UART initiates.

## Interface
- `DATA_WIDTH` — default 8 — byte width of both streams; only 8 is supported.
- `clk` in 1 — sole clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `s_axis_tdata` in 8 — received byte from the UART receiver.
- `s_axis_tvalid` in 1 — received byte is valid.
- `s_axis_tready` out 1 — block accepts the byte this cycle.
- `m_axis_tdata` out 8 — response byte to the UART transmitter.
- `m_axis_tvalid` out 1 — response byte is valid.
- `m_axis_tready` in 1 — transmitter accepts the byte.
- `busy_o` out 1 — high whenever the FSM is not in `OPCODE`.
- `err_o` out 1 — one-cycle pulse on a malformed or unknown frame.

## Operation
- Frame format: byte0 opcode, byte1 reserved (ignored), byte2 length LSB, byte3 length MSB. Length is the total frame bytes including the 4-byte header. Payload follows.
- Opcodes:
  - `0xEC` echo: each payload byte is returned unchanged, in order.
  - `0xA0` add: payload is N≥1 little-endian 32-bit operands; the wrapping sum is returned as 4 bytes, LSB first.
  - `0xB0` xor: same as add, but the reduction is XOR.
- FSM states: `OPCODE`, `RSVD`, `LEN_LO`, `LEN_HI`, `PAYLOAD`, `RESULT`, `DRAIN`, `ERR`.
  - `OPCODE` → `RSVD` → `LEN_LO` → `LEN_HI`, one accepted byte each.
  - At `LEN_HI` accept, validation runs:
    - length < 4, or an unknown opcode → `DRAIN`, `err_o`.
    - add/xor with (length−4) not a nonzero multiple of 4 → `DRAIN`, `err_o`.
    - echo with length == 4 → `OPCODE` (no response).
    - Otherwise → `PAYLOAD`.
- Payload counter: 16-bit `remaining` is loaded with length−4 and decrements per accepted payload byte. Leaving `PAYLOAD` happens on accepting the byte that brings `remaining` to 0.
- Add/xor data path:
  - A 32-bit operand shift register assembles bytes LSB first.
  - A 32-bit accumulator is cleared at `LEN_HI` and folded once per completed operand.
  - Carries out of bit 31 are discarded.
  - After the last operand → `RESULT`, which sends 4 bytes then returns to `OPCODE`.
- Echo data path:
  - One-entry output register.
  - `s_axis_tready = !m_axis_tvalid || m_axis_tready`, so a full-throughput pass-through is possible.
  - Returns to `OPCODE` once the last byte is transmitted.
- `DRAIN` accepts and discards bytes until `remaining` reaches 0. When length < 4, `remaining` is 0 and `DRAIN` exits immediately.
- `s_axis_tready` levels:
  - 1 in the header states, in add/xor `PAYLOAD`, and in `DRAIN`.
  - 0 in `RESULT` and `ERR`.

## Timing
- Reset values: `s_axis_tready` 0, `m_axis_tvalid` 0, `m_axis_tdata` 0x00, `busy_o` 0, `err_o` 0. State is `OPCODE`, accumulator and counters are 0.
- `s_axis_tready` rises 1 cycle after `rst_n` deasserts.
- Echo latency: byte accepted at edge k appears on `m_axis_tdata` with `m_axis_tvalid` after edge k.
- Add/xor latency: the first result byte is valid the cycle after the last operand byte is accepted.
- Once `m_axis_tvalid` is high, `m_axis_tdata` is held until `m_axis_tready`. `m_axis_tvalid` never drops without a transfer.
- Back-to-back frames: the next opcode may be accepted the cycle after the final response transfer.
- `err_o` asserts the cycle after the offending `LEN_HI` accept.
- Reset mid-frame: all state is cleared immediately, and any partial response is abandoned.

## Configuration
- `ALU_FRAME_RESP_ERR_REPLY_EN`
  - Defined: after `DRAIN` completes, the FSM enters `ERR` and sends the single byte `0xEE`, then returns to `OPCODE`.
  - Undefined: `ERR` is not compiled in. Malformed frames are drained silently; `err_o` still pulses.

## Test plan
- Echo: send `EC 00 07 00 41 42 43` → tx bytes `41 42 43`, then `busy_o`=0.
- Add with wrap: send `A0 00 0C 00 01 00 00 00 FF FF FF FF` → tx `00 00 00 00`.
- Xor of three operands: send `B0 00 10 00` plus `0F000000`, `F0000000`, `AA000000` (LE bytes) → tx `55 00 00 00`.
- Backpressure: echo `EC 00 06 00 11 22` with `m_axis_tready` low for 10 cycles → `11` held stable, no loss, then `22`.
- Bad frame: send `A0 00 07 00 01 02 03` → `err_o` pulse.
  - With the macro: tx `EE`.
  - Without the macro: no tx.
  - In both cases a following valid add returns a correct sum.
- Mid-frame reset: assert `rst_n`=0 after `A0 00 0C 00 01` → all outputs at reset values; a fresh echo frame then works.
